// File: rtl/score_timer_bcd_pkg.sv
// score_pkg: shared constants and the controller state type for score_timer_bcd.
//   ST_IDLE / ST_RUN / ST_OVER : controller states (2'b11 is unused and recovers to idle)
//   BCD_DIGITS, SCORE_W        : packed-BCD score geometry
//   SCORE_MAX                  : saturation value of the score
package score_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int SCORE_W    = 16;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_e;

endpackage

// File: rtl/score_timer_bcd_inc4.sv
// bcd_inc4: combinational packed-BCD +1 with saturation at 9999.
// Ports:
//   bcd_in  [15:0] : current value, 4 packed BCD digits
//   bcd_out [15:0] : bcd_in + 1 in BCD, or bcd_in unchanged when saturated
//   sat            : bcd_in is already at 9999
module bcd_inc4
  import score_pkg::*;
(
  input  logic [SCORE_W-1:0] bcd_in,
  output logic [SCORE_W-1:0] bcd_out,
  output logic               sat
);

  logic carry;

  always_comb begin
    bcd_out = bcd_in;
    sat     = (bcd_in == SCORE_MAX);
    carry   = !sat;
    // Ripple the +1 from the units digit upward; a 9 wraps to 0 and passes the carry on.
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (carry) begin
        if (bcd_in[4*i +: 4] == 4'd9) begin
          bcd_out[4*i +: 4] = 4'd0;
        end else begin
          bcd_out[4*i +: 4] = bcd_in[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/score_timer_bcd.sv
// score_timer_bcd: game score timer. While a run is active it counts 1 kHz tick
// pulses and advances a 4-digit packed BCD score every TICKS_PER_POINT ticks.
// A collision freezes the score; start begins a new run from zero.
//
// Build option: define SCORE_HISCORE_EN to keep a high score. Without it,
// hiscore_bcd is tied to 0 and new_record to 0.
//
// Ports:
//   clk_in      : system clock
//   reset       : asynchronous, active-high clear of all state
//   tick        : one-cycle 1 kHz pulse
//   start       : starts a run from IDLE or OVER
//   collide     : ends the current run
//   score_bcd   : current score, packed BCD, [15:12] = thousands
//   hiscore_bcd : best score since reset (packed BCD)
//   running     : high in RUN
//   game_over   : high in OVER
//   new_record  : one-cycle pulse when hiscore_bcd is updated
//
// state   | meaning
// IDLE    | after reset; score and prescaler held at 0
// RUN     | counting ticks, score advancing
// OVER    | run ended by collide; score frozen until start
module score_timer_bcd
  import score_pkg::*;
#(
  parameter int TICKS_PER_POINT = 100,
  parameter int PRESCALE_W      = 10
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               collide,
  output logic [SCORE_W-1:0] score_bcd,
  output logic [SCORE_W-1:0] hiscore_bcd,
  output logic               running,
  output logic               game_over,
  output logic               new_record
);

  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(TICKS_PER_POINT - 1);
  localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);

  state_e                 state_q, state_d;
  logic [PRESCALE_W-1:0]  presc_q, presc_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic                   running_q, running_d;
  logic                   game_over_q, game_over_d;
  logic [SCORE_W-1:0]     inc_out;
  logic                   inc_sat;

  bcd_inc4 u_inc (
    .bcd_in  (score_q),
    .bcd_out (inc_out),
    .sat     (inc_sat)
  );

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    score_d = score_q;
    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        score_d = '0;
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        // collide takes priority over a tick in the same cycle
        if (collide) begin
          state_d = ST_OVER;
        end else if (tick) begin
          if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            score_d = inc_sat ? score_q : inc_out;
          end else begin
            presc_d = presc_q + PRESC_ONE;
          end
        end
      end
      ST_OVER: begin
        if (start) begin
          state_d = ST_RUN;
          presc_d = '0;
          score_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        presc_d = '0;
        score_d = '0;
      end
    endcase
    // Flag outputs decode the next state so they line up with state_q.
    running_d   = (state_d == ST_RUN);
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      score_q     <= '0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      score_q     <= score_d;
      running_q   <= running_d;
      game_over_q <= game_over_d;
    end
  end

  assign score_bcd = score_q;
  assign running   = running_q;
  assign game_over = game_over_q;

`ifdef SCORE_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q, hiscore_d;
  logic               new_record_q, new_record_d;

  // Packed BCD orders the same as its unsigned binary value, so a plain compare works.
  always_comb begin
    hiscore_d    = hiscore_q;
    new_record_d = 1'b0;
    if (state_q == ST_RUN && collide && score_q > hiscore_q) begin
      hiscore_d    = score_q;
      new_record_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      hiscore_q    <= '0;
      new_record_q <= 1'b0;
    end else begin
      hiscore_q    <= hiscore_d;
      new_record_q <= new_record_d;
    end
  end

  assign hiscore_bcd = hiscore_q;
  assign new_record  = new_record_q;
`else
  assign hiscore_bcd = '0;
  assign new_record  = 1'b0;
`endif

endmodule

// File: tb/tb_score_timer_bcd.sv
module tb_score_timer_bcd;

  localparam int TPP = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_OVER = 2;

  logic        clk_in;
  logic        reset;
  logic        tick;
  logic        start;
  logic        collide;
  logic [15:0] score_bcd;
  logic [15:0] hiscore_bcd;
  logic        running;
  logic        game_over;
  logic        new_record;

  int total;
  int bad;

  // reference model state
  int m_mode;
  int m_run_ticks;
  int m_hi;
  bit m_pulse;

  score_timer_bcd #(.TICKS_PER_POINT(TPP), .PRESCALE_W(10)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .tick        (tick),
    .start       (start),
    .collide     (collide),
    .score_bcd   (score_bcd),
    .hiscore_bcd (hiscore_bcd),
    .running     (running),
    .game_over   (game_over),
    .new_record  (new_record)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic int m_score();
    int s;
    s = m_run_ticks / TPP;
    if (s > 9999) s = 9999;
    return s;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode      = M_IDLE;
    m_run_ticks = 0;
    m_hi        = 0;
    m_pulse     = 1'b0;
  endtask

  task automatic model_edge(input bit t, input bit s, input bit c);
    m_pulse = 1'b0;
    case (m_mode)
      M_IDLE: if (s) begin m_mode = M_RUN; m_run_ticks = 0; end
      M_RUN: begin
        if (c) begin
          m_mode = M_OVER;
`ifdef SCORE_HISCORE_EN
          if (m_score() > m_hi) begin
            m_hi    = m_score();
            m_pulse = 1'b1;
          end
`endif
        end else if (t) begin
          m_run_ticks++;
        end
      end
      default: if (s) begin m_mode = M_RUN; m_run_ticks = 0; end
    endcase
  endtask

  task automatic compare_all();
    check("score", score_bcd, to_bcd(m_score()));
    check("running", {15'b0, running}, {15'b0, m_mode == M_RUN});
    check("game_over", {15'b0, game_over}, {15'b0, m_mode == M_OVER});
    check("hiscore", hiscore_bcd, to_bcd(m_hi));
    check("new_record", {15'b0, new_record}, {15'b0, m_pulse});
  endtask

  // Called at a negedge: drive inputs, apply the edge to the model, check at the next negedge.
  task automatic step(input bit t, input bit s, input bit c);
    tick = t; start = s; collide = c;
    @(posedge clk_in);
    model_edge(t, s, c);
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic ticks_until(input int target);
    for (int i = 0; i < 50000 && m_run_ticks < target; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic play_run(input int pts, input logic [15:0] exp_hi, input bit exp_pulse);
    step(1'b0, 1'b1, 1'b0);
    check("lit_restart_zero", score_bcd, 16'h0000);
    for (int i = 0; i < pts * TPP; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("lit_run_score", score_bcd, to_bcd(pts));
    check("lit_hiscore", hiscore_bcd, exp_hi);
    check("lit_pulse", {15'b0, new_record}, {15'b0, exp_pulse});
    step(1'b0, 1'b0, 1'b0);
    check("lit_pulse_gone", {15'b0, new_record}, 16'h0000);
  endtask

  initial begin
    total = 0; bad = 0;
    model_reset();
    reset = 1'b1; tick = 1'b0; start = 1'b0; collide = 1'b0;
    repeat (3) @(negedge clk_in);
    check("lit_reset_score", score_bcd, 16'h0000);
    check("lit_reset_flags", {13'b0, running, game_over, new_record}, 16'h0000);
    reset = 1'b0;
    @(negedge clk_in);
    compare_all();

    // collide in IDLE is ignored; start enters RUN
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    check("lit_running", {15'b0, running}, 16'h0001);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (k == 4) check("lit_tick4", score_bcd, 16'h0001);
      if (k == 8) check("lit_tick8", score_bcd, 16'h0002);
      repeat (9) step(1'b0, 1'b0, 1'b0);
    end

    // start ignored in RUN; digit carries and saturation
    step(1'b1, 1'b1, 1'b0);
    ticks_until(99 * TPP);
    check("lit_0099", score_bcd, 16'h0099);
    ticks_until(100 * TPP);
    check("lit_0100", score_bcd, 16'h0100);
    ticks_until(9999 * TPP);
    check("lit_9999", score_bcd, 16'h9999);
    repeat (3 * TPP) step(1'b1, 1'b0, 1'b0);
    check("lit_sat", score_bcd, 16'h9999);

    // end the run, restart with start+collide (start wins)
    step(1'b0, 1'b0, 1'b1);
    check("lit_over", {15'b0, game_over}, 16'h0001);
    step(1'b0, 1'b1, 1'b1);
    check("lit_start_wins", {14'b0, running, game_over}, 16'h0002);
    // prescaler at 3, tick with collide: no increment
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("lit_collide_tick", score_bcd, 16'h0000);
    check("lit_collide_over", {15'b0, game_over}, 16'h0001);

    // asynchronous reset mid-run at score 42
    step(1'b0, 1'b1, 1'b0);
    ticks_until(42 * TPP);
    check("lit_0042", score_bcd, 16'h0042);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("lit_async_score", score_bcd, 16'h0000);
    check("lit_async_hi", hiscore_bcd, 16'h0000);
    check("lit_async_flags", {13'b0, running, game_over, new_record}, 16'h0000);
    @(negedge clk_in);
    reset = 1'b0;
    step(1'b0, 1'b0, 1'b0);

    // three runs for the high score
`ifdef SCORE_HISCORE_EN
    play_run(5, 16'h0005, 1'b1);
    play_run(3, 16'h0005, 1'b0);
    play_run(7, 16'h0007, 1'b1);
`else
    play_run(5, 16'h0000, 1'b0);
    play_run(3, 16'h0000, 1'b0);
    play_run(7, 16'h0000, 1'b0);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 1) == 1), ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
